vga_board_renderer: RTL and testbench
=====================================

VGA_BOARD_RENDERER -- requirements
Module: vga_board_renderer

Interface
REQ-001 SHALL have a single clock, with reset asynchronous and active-low.
REQ-002 SHALL define port clk, input, 1 bit: 25 MHz pixel clock; all state on rising edge.
REQ-003 SHALL define port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL define port board_flattened, input, 230 bits: 23 rows x 10 cells; row r, column c at bit 229-(10r+c); 1 = occupied.
REQ-005 SHALL define port hsync, output, 1 bit: horizontal sync, active-low.
REQ-006 SHALL define port vsync, output, 1 bit: vertical sync, active-low.
REQ-007 SHALL define ports red, green and blue, output, 4 bits each: pixel colour, zero outside the visible area.
REQ-008 SHALL define port frame_start, output, 1 bit: one-cycle pulse marking pixel (0,0).
REQ-009 SHALL define port snap_taken, output, 1 bit: one-cycle pulse when a board snapshot is latched.

Function
REQ-010 SHALL implement 10-bit h_cnt over 0..799, wrapping 799->0.
REQ-011 SHALL increment 10-bit v_cnt when h_cnt wraps, over 0..524, wrapping 524->0.
REQ-012 SHALL drive hsync low for h_cnt 656..751 inclusive (640 visible, 16 front porch, 96 sync, 48 back porch).
REQ-013 SHALL drive vsync low for v_cnt 490..491 inclusive (480 visible, 10 front porch, 2 sync, 33 back porch).
REQ-014 SHALL latch board_flattened into a 230-bit snapshot register on the cycle h_cnt==0 and v_cnt==480, and pulse snap_taken on that same cycle.
REQ-015 SHALL leave the snapshot unchanged at all other times; rendering uses only the snapshot, never board_flattened directly.
REQ-016 SHALL render only rows 3..22; rows 0..2 are hidden spawn rows and never drawn.
REQ-017 SHALL place the board area at x 220..419 and y 40..439, with 20x20-pixel cells.
REQ-018 SHALL compute col = (x-220)/20 and row = (y-40)/20 + 3, using counters or comparisons rather than true division.
REQ-019 SHALL colour an occupied cell R=F, G=F, B=0 and an empty cell R=0, G=0, B=2.
REQ-020 SHALL draw a 4-pixel border ring around the board area (x 216..219 and 420..423 over y 36..443; y 36..39 and 440..443 over x 216..423) in white, F/F/F.
REQ-021 SHALL output all other visible pixels as 0/0/0.
REQ-022 SHALL output RGB 0 for any h_cnt>=640 or v_cnt>=480.
REQ-023 SHALL register all outputs, giving a latency of exactly 1 clock from counter value to hsync, vsync, RGB, frame_start and snap_taken, identical for all of them.
REQ-024 SHALL assert frame_start for one cycle, corresponding to counter state h=0, v=0.

Reset
REQ-025 SHALL, while rst_n is low, force h_cnt=0, v_cnt=0, snapshot=0, hsync=1, vsync=1, RGB=0, frame_start=0 and snap_taken=0.
REQ-026 SHALL take effect immediately on assertion mid-frame, without waiting for a clock edge.
REQ-027 SHALL, on the first rising edge after deassertion, evaluate counters (0,0), so frame_start=1 one cycle later.
REQ-028 SHALL render an empty board after reset (snapshot=0) until the first snapshot at v_cnt=480.

Configuration
REQ-029 SHALL, when macro GRID_LINES_EN is defined, draw a 1-pixel grid line in colour 3/3/3 on every cell pixel where (x-220) mod 20 == 0 or (y-40) mod 20 == 0, overriding the cell colour inside the board area.
REQ-030 SHALL, when GRID_LINES_EN is undefined, generate no grid logic and fill cells solid per REQ-019.

Verification
REQ-031 SHALL cover reset, then run 420,000 clocks -> hsync low pulses exactly 96 cycles wide with period 800; vsync low pulses 1,600 cycles wide with period 420,000; frame_start period 420,000.
REQ-032 SHALL cover driving board_flattened with only bit 229-(10*22+0) set -> first visible frame after snapshot shows F/F/0 at x 220..239, y 420..439, and B=2 elsewhere in the board.
REQ-033 SHALL cover setting row 1 bits all ones -> no yellow pixel anywhere (hidden row).
REQ-034 SHALL cover changing board_flattened at v_cnt=200 -> current frame unchanged; new content appears only after snap_taken at v_cnt=480.
REQ-035 SHALL cover pixel (216,100) -> F/F/F; pixel (640,100) -> 0/0/0; with GRID_LINES_EN, pixel (240,100) -> 3/3/3.
REQ-036 SHALL cover asserting rst_n low at h=300, v=250 -> outputs reset values asynchronously; after release, frame_start occurs one cycle after first edge.

Source files
------------

// File: rtl/vga_board_renderer.sv
// 640x480@60 VGA renderer for a 10x20 visible board (23 rows, top 3 hidden), snapshot taken at v=480.
// Optional macro GRID_LINES_EN overlays a 1-pixel 3/3/3 grid on cell boundaries.
module vga_board_renderer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [229:0] board_flattened,
   output logic         hsync,
   output logic         vsync,
   output logic [3:0]   red,
   output logic [3:0]   green,
   output logic [3:0]   blue,
   output logic         frame_start,
   output logic         snap_taken
);

   logic [9:0]   h_cnt;
   logic [9:0]   v_cnt;
   logic [229:0] snapshot;
   logic [3:0]   col_cnt;
   logic [4:0]   x_sub;
   logic [4:0]   row_cnt;
   logic [4:0]   y_sub;

   logic         visible;
   logic         in_board;
   logic         in_ring;
   logic [7:0]   cell_lin;
   logic [7:0]   cell_idx;
   logic         cell_occ;
   logic [11:0]  pix_rgb;

   // Cell position is tracked by counters that re-arm one pixel/line before the board edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt   <= 10'd0;
         v_cnt   <= 10'd0;
         col_cnt <= 4'd0;
         x_sub   <= 5'd0;
         row_cnt <= 5'd0;
         y_sub   <= 5'd0;
      end else begin
         if (h_cnt == 10'd799) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
            if (v_cnt == 10'd39) begin
               row_cnt <= 5'd3;
               y_sub   <= 5'd0;
            end else if (y_sub == 5'd19) begin
               row_cnt <= row_cnt + 5'd1;
               y_sub   <= 5'd0;
            end else begin
               y_sub <= y_sub + 5'd1;
            end
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end

         if (h_cnt == 10'd219) begin
            col_cnt <= 4'd0;
            x_sub   <= 5'd0;
         end else if (x_sub == 5'd19) begin
            col_cnt <= col_cnt + 4'd1;
            x_sub   <= 5'd0;
         end else begin
            x_sub <= x_sub + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         snapshot <= '0;
      else if (h_cnt == 10'd0 && v_cnt == 10'd480)
         snapshot <= board_flattened;
   end

   always_comb begin
      visible  = (h_cnt < 10'd640) && (v_cnt < 10'd480);
      in_board = (h_cnt >= 10'd220) && (h_cnt <= 10'd419) &&
                 (v_cnt >= 10'd40)  && (v_cnt <= 10'd439);
      in_ring  = (h_cnt >= 10'd216) && (h_cnt <= 10'd423) &&
                 (v_cnt >= 10'd36)  && (v_cnt <= 10'd443) && !in_board;
      cell_lin = ({3'b000, row_cnt} * 8'd10) + {4'b0000, col_cnt};
      cell_idx = 8'd229 - cell_lin;
      cell_occ = snapshot[cell_idx];
      pix_rgb  = 12'h000;
      if (visible) begin
         if (in_board) begin
            pix_rgb = cell_occ ? 12'hFF0 : 12'h002;
`ifdef GRID_LINES_EN
            if (x_sub == 5'd0 || y_sub == 5'd0)
               pix_rgb = 12'h333;
`endif
         end else if (in_ring) begin
            pix_rgb = 12'hFFF;
         end
      end
   end

   // Output stage: every output is one register behind the counter state it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         red         <= 4'd0;
         green       <= 4'd0;
         blue        <= 4'd0;
         frame_start <= 1'b0;
         snap_taken  <= 1'b0;
      end else begin
         hsync       <= !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
         vsync       <= !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
         red         <= pix_rgb[11:8];
         green       <= pix_rgb[7:4];
         blue        <= pix_rgb[3:0];
         frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
         snap_taken  <= (h_cnt == 10'd0) && (v_cnt == 10'd480);
      end
   end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer: reference model built from screen geometry with plain arithmetic,
// compared per scan line (signature) plus targeted pixel and pulse-timing checks.
module tb_vga_board_renderer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [229:0] board;
   logic         hsync, vsync, frame_start, snap_taken;
   logic [3:0]   red, green, blue;

   vga_board_renderer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .board_flattened (board),
      .hsync           (hsync),
      .vsync           (vsync),
      .red             (red),
      .green           (green),
      .blue            (blue),
      .frame_start     (frame_start),
      .snap_taken      (snap_taken)
   );

   always #20 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           st_idx;
   logic [229:0] model_snap;
   logic [31:0]  obs_sig, exp_sig;
   int           yellow_cnt;
   logic         prev_hs, prev_vs;
   int           hs_fall, vs_fall, fs_last;
   int           hs_width, hs_period, vs_width, vs_period, fs_period;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ref_rgb(input int x, input int y, input logic [229:0] snap);
      int col, row;
      if (x >= 640 || y >= 480) return 12'h000;
      if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
         col = (x - 220) / 20;
         row = (y - 40) / 20 + 3;
`ifdef GRID_LINES_EN
         if ((x - 220) % 20 == 0 || (y - 40) % 20 == 0) return 12'h333;
`endif
         return snap[229 - (10 * row + col)] ? 12'hFF0 : 12'h002;
      end
      if (x >= 216 && x < 424 && y >= 36 && y < 444) return 12'hFFF;
      return 12'h000;
   endfunction

   function automatic logic [15:0] ref_word(input int h, input int v, input logic [229:0] snap);
      logic hs, vs, fs, st;
      hs = !(h >= 656 && h <= 751);
      vs = !(v >= 490 && v <= 491);
      fs = (h == 0 && v == 0);
      st = (h == 0 && v == 480);
      return {hs, vs, fs, st, ref_rgb(h, v, snap)};
   endfunction

   function automatic logic [15:0] obs_word();
      return {hsync, vsync, frame_start, snap_taken, red, green, blue};
   endfunction

   task automatic restart_model();
      st_idx     = -1;
      model_snap = '0;
      obs_sig    = 32'd0;
      exp_sig    = 32'd0;
      yellow_cnt = 0;
      prev_hs    = 1'b1;
      prev_vs    = 1'b1;
      hs_fall    = -1;
      vs_fall    = -1;
      fs_last    = -1;
   endtask

   // One clock: sample the outputs for the counter state evaluated at the last rising edge.
   task automatic step();
      int h, v, frame;
      logic [15:0] ow, ew;
      @(negedge clk);
      st_idx++;
      h     = st_idx % 800;
      v     = (st_idx / 800) % 525;
      frame = st_idx / 420000;
      ow    = obs_word();
      ew    = ref_word(h, v, model_snap);
      if (h == 0 && v == 480) model_snap = board;
      obs_sig = (obs_sig * 32'd33) ^ {16'd0, ow};
      exp_sig = (exp_sig * 32'd33) ^ {16'd0, ew};
      if (h == 799) begin
         check($sformatf("line_sig f%0d v%0d", frame, v), obs_sig, exp_sig);
         obs_sig = 32'd0;
         exp_sig = 32'd0;
      end
      if (ow[11:0] == 12'hFF0) yellow_cnt++;
      if (prev_hs && !hsync) begin
         if (hs_fall >= 0) hs_period = st_idx - hs_fall;
         hs_fall = st_idx;
      end
      if (!prev_hs && hsync) hs_width = st_idx - hs_fall;
      if (prev_vs && !vsync) begin
         if (vs_fall >= 0) vs_period = st_idx - vs_fall;
         vs_fall = st_idx;
      end
      if (!prev_vs && vsync) vs_width = st_idx - vs_fall;
      if (frame_start) begin
         if (fs_last >= 0) fs_period = st_idx - fs_last;
         fs_last = st_idx;
      end
      prev_hs = hsync;
      prev_vs = vsync;
      if (frame == 1) begin
         if (h == 216 && v == 100) check("px_216_100", 32'(ow[11:0]), 32'h FFF);
         if (h == 640 && v == 100) check("px_640_100", 32'(ow[11:0]), 32'h000);
         if (h == 221 && v == 421) check("px_r22_c0", 32'(ow[11:0]), 32'hFF0);
         if (h == 241 && v == 421) check("px_r22_c1", 32'(ow[11:0]), 32'h002);
`ifdef GRID_LINES_EN
         if (h == 240 && v == 100) check("px_grid_240_100", 32'(ow[11:0]), 32'h333);
`endif
      end
   endtask

   logic [229:0] board_a, board_b;

   initial begin
      hs_width = 0; hs_period = 0; vs_width = 0; vs_period = 0; fs_period = 0;
      board_a = '0;
      board_a[229 - 220] = 1'b1;
      for (int c = 0; c < 10; c++) board_a[229 - (10 + c)] = 1'b1;
      for (int i = 0; i < 230; i++) board_b[i] = 1'($urandom_range(0, 1));

      rst_n = 1'b0;
      board = board_a;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(obs_word()), 32'h0000C000);
      rst_n = 1'b1;
      restart_model();

      // Frame 0: snapshot still zero, board A captured at v=480.
      for (int i = 0; i < 420000; i++) step();
      check("yellow_frame0", 32'(yellow_cnt), 32'd0);
      yellow_cnt = 0;

      // Frame 1: shows A; board switched to B mid-frame must not show yet.
      for (int i = 0; i < 420000; i++) begin
         step();
         if (st_idx == 420000 + 200 * 800) board = board_b;
      end
`ifdef GRID_LINES_EN
      check("yellow_frame1", 32'(yellow_cnt), 32'd361);
`else
      check("yellow_frame1", 32'(yellow_cnt), 32'd400);
`endif

      // Frame 2: shows B up to h=299, v=250, then asynchronous reset.
      while (st_idx < 840000 + 250 * 800 + 299) step();
      check("hsync_width", 32'(hs_width), 32'd96);
      check("hsync_period", 32'(hs_period), 32'd800);
      check("vsync_width", 32'(vs_width), 32'd1600);
      check("vsync_period", 32'(vs_period), 32'd420000);
      check("frame_start_period", 32'(fs_period), 32'd420000);
      check("pre_reset_rgb_nonzero", 32'(obs_word()[11:0] != 12'h000), 32'd1);

      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", 32'(obs_word()), 32'h0000C000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_held", 32'(obs_word()), 32'h0000C000);
      end
      for (int i = 0; i < 230; i++) board[i] = 1'($urandom_range(0, 1));
      rst_n = 1'b1;
      restart_model();
      step();
      check("frame_start_after_release", 32'(frame_start), 32'd1);
      for (int i = 1; i < 60 * 800; i++) step();
      check("yellow_after_reset", 32'(yellow_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
